// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
package int_ctrl_pkg;

    // Controller FSM state; the encoding is visible through the STATUS register.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // Word addresses of the configuration registers.
    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // After reset every source is edge-triggered.
    localparam logic [31:0] MODE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/int_ctrl_if.sv
// Core-side bus of the interrupt controller: register port plus req/ack/eret.
// Handshake: o_int_req stays high with a constant o_int_cause until the core
// pulses i_int_ack for one cycle; the core then pulses i_eret once to leave
// the handler. Register reads are combinational from i_reg_addr; writes take
// effect on the clock edge where i_reg_we is high.
interface int_ctrl_if #(
    parameter int CAUSE_W = 3
);
    logic               i_reg_we;
    logic [1:0]         i_reg_addr;
    logic [31:0]        i_reg_wdata;
    logic [31:0]        o_reg_rdata;
    logic               o_int_req;
    logic [CAUSE_W-1:0] o_int_cause;
    logic               i_int_ack;
    logic               i_eret;

    modport slave (
        input  i_reg_we, i_reg_addr, i_reg_wdata, i_int_ack, i_eret,
        output o_reg_rdata, o_int_req, o_int_cause
    );

    modport master (
        output i_reg_we, i_reg_addr, i_reg_wdata, i_int_ack, i_eret,
        input  o_reg_rdata, o_int_req, o_int_cause
    );
endinterface

// File: rtl/int_ctrl_sync.sv
// Per-source synchroniser: SYNC_STAGES flops, plus a delay flop that turns
// the synchronised level into a one-cycle rising-edge pulse.
module int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Shift the raw line through the chain and remember the previous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~dly_q;
endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronise, latch/mask, fixed-priority select and
// present one source to the core with a req/ack/eret handshake.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 5,
    parameter int SYNC_STAGES = 2,
    parameter int CAUSE_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] i_interruption,
    int_ctrl_if.slave          bus
);
    localparam int VEC_W = 1 << CAUSE_W;

    logic [NUM_SRC-1:0] level, rise;
    logic [NUM_SRC-1:0] mask_q, mode_q, pending_q, pending_d;
    logic [NUM_SRC-1:0] clr_vec, eff;
    logic [VEC_W-1:0]   eff_wide;
    logic [CAUSE_W-1:0] prio_idx, cause_q, cause_d;
    state_e             state_q, state_d;
    logic               ack_fire, w1c;
    logic               unused_wdata;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst_n   (reset),
            .async_i (i_interruption[g]),
            .level_o (level[g]),
            .rise_o  (rise[g])
        );
    end

    assign ack_fire = (state_q == REQ) && bus.i_int_ack;
    assign w1c      = bus.i_reg_we && (bus.i_reg_addr == ADDR_PENDING);
    assign eff      = pending_q & mask_q;

    // Clear requests for edge sources: ack of the latched cause or a W1C write.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_vec[i] = (ack_fire && (cause_q == CAUSE_W'(i))) ||
                         (w1c && bus.i_reg_wdata[i]);
        end
    end

    // Edge sources: a new edge beats a simultaneous clear. Level sources mirror the line.
    assign pending_d = (mode_q & (rise | (pending_q & ~clr_vec))) | (~mode_q & level);

    // Widen the effective vector so the latched cause can index it directly.
    always_comb begin
        eff_wide = '0;
        eff_wide[NUM_SRC-1:0] = eff;
    end

    // Fixed priority: scanning downwards leaves the lowest active index.
    always_comb begin
        prio_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eff[i]) prio_idx = CAUSE_W'(i);
        end
    end

    // Next-state logic; a request is withdrawn only if its own source drops.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (|eff) begin
                    state_d = REQ;
                    cause_d = prio_idx;
                end
            end
            REQ: begin
                if (bus.i_int_ack)          state_d = SERVICE;
                else if (!eff_wide[cause_q]) state_d = IDLE;
            end
            SERVICE: begin
                if (bus.i_eret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and latched cause.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Configuration registers and the pending vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q    <= '0;
            mode_q    <= MODE_RST[NUM_SRC-1:0];
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (bus.i_reg_we && bus.i_reg_addr == ADDR_MASK) mask_q <= bus.i_reg_wdata[NUM_SRC-1:0];
            if (bus.i_reg_we && bus.i_reg_addr == ADDR_MODE) mode_q <= bus.i_reg_wdata[NUM_SRC-1:0];
        end
    end

    // Combinational read mux; bits above each field read as zero.
    always_comb begin
        bus.o_reg_rdata = '0;
        case (bus.i_reg_addr)
            ADDR_MASK:    bus.o_reg_rdata[NUM_SRC-1:0] = mask_q;
            ADDR_MODE:    bus.o_reg_rdata[NUM_SRC-1:0] = mode_q;
            ADDR_PENDING: bus.o_reg_rdata[NUM_SRC-1:0] = pending_q;
            default: begin
                bus.o_reg_rdata[1:0]         = state_q;
                bus.o_reg_rdata[2 +: CAUSE_W] = cause_q;
            end
        endcase
    end

    assign bus.o_int_req   = (state_q == REQ);
    assign bus.o_int_cause = cause_q;

    // Write-data bits above the source count have no destination.
    assign unused_wdata = ^bus.i_reg_wdata[31:NUM_SRC];
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed stimulus with hand-computed expectations,
// checked by a negedge monitor that pops an expected queue.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    localparam int NUM_SRC = 5;
    localparam int CAUSE_W = 3;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_SRC-1:0] irq   = '0;

    int_ctrl_if #(.CAUSE_W(CAUSE_W)) bus ();

    int_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(2), .CAUSE_W(CAUSE_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_interruption (irq),
        .bus            (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    logic [CAUSE_W-1:0] exp_cause_q[$];
    logic [31:0]        exp_rd_q[$];
    logic [0:0]         exp_lvl_q[$];
    string              tag_rd_q[$];
    string              tag_lvl_q[$];
    logic               rd_chk  = 1'b0;
    logic               lvl_chk = 1'b0;
    logic               to_flag = 1'b0;
    logic               end_chk = 1'b0;
    logic               req_prev = 1'b0;
    int                 vectors = 0;
    int                 miscompares = 0;

    // Monitor: compares whatever the DUT presents against the expected queues.
    always @(negedge clk) begin
        logic [31:0] e_rd;
        logic [0:0]  e_lvl;
        logic [CAUSE_W-1:0] e_c;
        string t;
        if (rd_chk && exp_rd_q.size() > 0) begin
            e_rd = exp_rd_q.pop_front();
            t = tag_rd_q.pop_front();
            vectors++;
            if (bus.o_reg_rdata !== e_rd) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h required 0x%08h", t, bus.o_reg_rdata, e_rd);
            end
        end
        if (lvl_chk && exp_lvl_q.size() > 0) begin
            e_lvl = exp_lvl_q.pop_front();
            t = tag_lvl_q.pop_front();
            vectors++;
            if (bus.o_int_req !== e_lvl) begin
                miscompares++;
                $display("FAIL %s: o_int_req got %b required %b", t, bus.o_int_req, e_lvl);
            end
        end
        if (to_flag) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: o_int_req got %b required 1", bus.o_int_req);
        end
        if (bus.o_int_req === 1'b1 && !req_prev) begin
            vectors++;
            if (exp_cause_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_req: cause got %0d required no request", bus.o_int_cause);
            end else begin
                e_c = exp_cause_q.pop_front();
                if (bus.o_int_cause !== e_c) begin
                    miscompares++;
                    $display("FAIL req_cause: got %0d required %0d", bus.o_int_cause, e_c);
                end
            end
        end
        if (end_chk) begin
            vectors++;
            if (exp_cause_q.size() != 0) begin
                miscompares++;
                $display("FAIL missing_req: %0d requests outstanding, required 0", exp_cause_q.size());
            end
        end
        req_prev = (bus.o_int_req === 1'b1);
    end

    // Driver tasks (all start and end one time unit after a rising edge)
    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus.i_reg_we    = 1'b1;
        bus.i_reg_addr  = addr;
        bus.i_reg_wdata = data;
        @(posedge clk); #1;
        bus.i_reg_we    = 1'b0;
        bus.i_reg_wdata = '0;
    endtask

    task automatic check_rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
        bus.i_reg_addr = addr;
        exp_rd_q.push_back(exp);
        tag_rd_q.push_back(tag);
        rd_chk = 1'b1;
        @(posedge clk); #1;
        rd_chk = 1'b0;
    endtask

    task automatic check_req(input logic exp, input string tag);
        exp_lvl_q.push_back(exp);
        tag_lvl_q.push_back(tag);
        lvl_chk = 1'b1;
        @(posedge clk); #1;
        lvl_chk = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.i_int_ack = 1'b1;
        @(posedge clk); #1;
        bus.i_int_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        bus.i_eret = 1'b1;
        @(posedge clk); #1;
        bus.i_eret = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (bus.o_int_req !== 1'b1 && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.o_int_req !== 1'b1) begin
            to_flag = 1'b1;
            @(posedge clk); #1;
            to_flag = 1'b0;
        end
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        bus.i_reg_we    = 1'b0;
        bus.i_reg_addr  = '0;
        bus.i_reg_wdata = '0;
        bus.i_int_ack   = 1'b0;
        bus.i_eret      = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // 1: asynchronous reset while source 1 is requesting
        wr(ADDR_MASK, 32'h2);
        exp_cause_q.push_back(3'd1);
        irq[1] = 1'b1;
        wait_req(10);
        @(negedge clk);
        @(posedge clk); #1;
        reset  = 1'b0;
        irq[1] = 1'b0;
        check_req(1'b0, "req_async_reset");
        idle(2);
        reset = 1'b1;
        check_rd(ADDR_MASK,    32'h0,  "rst_mask");
        check_rd(ADDR_MODE,    32'h1F, "rst_mode");
        check_rd(ADDR_PENDING, 32'h0,  "rst_pending");
        check_rd(ADDR_STATUS,  32'h0,  "rst_status");

        // 2: single edge source, latency and service cycle
        wr(ADDR_MASK, 32'h1);
        exp_cause_q.push_back(3'd0);
        irq[0] = 1'b1;
        idle(3);
        check_req(1'b0, "latency_edge3");
        check_req(1'b1, "latency_edge4");
        pulse_ack();
        check_rd(ADDR_STATUS,  32'h2, "svc_status");
        check_rd(ADDR_PENDING, 32'h0, "ack_clears_pending");
        pulse_ack();
        check_rd(ADDR_STATUS,  32'h2, "ack_in_service");
        pulse_eret();
        check_rd(ADDR_STATUS,  32'h0, "eret_to_idle");
        idle(8);
        irq[0] = 1'b0;
        idle(4);

        // 3: two sources together, lowest index first, one idle cycle between
        wr(ADDR_MASK, 32'h1F);
        exp_cause_q.push_back(3'd1);
        exp_cause_q.push_back(3'd3);
        irq[1] = 1'b1;
        irq[3] = 1'b1;
        wait_req(12);
        check_rd(ADDR_STATUS, 32'h5, "prio_lowest");
        pulse_eret();
        check_rd(ADDR_STATUS, 32'h5, "eret_in_req");
        pulse_ack();
        check_rd(ADDR_PENDING, 32'h8, "pending_after_ack");
        pulse_eret();
        check_req(1'b0, "idle_gap");
        check_req(1'b1, "rereq");
        check_rd(ADDR_STATUS, 32'hD, "second_cause");
        pulse_ack();
        pulse_eret();
        check_rd(ADDR_STATUS, 32'hC, "cause_held_idle");
        irq[1] = 1'b0;
        irq[3] = 1'b0;
        idle(4);

        // 4: level source 2, W1C ignored, request withdrawn on drop
        wr(ADDR_MODE, 32'h1B);
        exp_cause_q.push_back(3'd2);
        irq[2] = 1'b1;
        wait_req(12);
        check_rd(ADDR_STATUS, 32'h9, "level_req");
        wr(ADDR_PENDING, 32'h4);
        check_rd(ADDR_PENDING, 32'h4, "level_w1c_ignored");
        check_rd(ADDR_STATUS,  32'h9, "level_still_req");
        irq[2] = 1'b0;
        idle(3);
        check_req(1'b1, "drop_edge3");
        check_req(1'b0, "drop_edge4");
        check_rd(ADDR_STATUS, 32'h8, "level_withdrawn");
        idle(4);

        // 5: masked edge source 4, set beats a simultaneous W1C
        wr(ADDR_MODE, 32'h1F);
        wr(ADDR_MASK, 32'h0F);
        irq[4] = 1'b1;
        idle(4);
        check_rd(ADDR_PENDING, 32'h10, "masked_pending");
        irq[4] = 1'b0;
        idle(4);
        irq[4] = 1'b1;
        idle(2);
        wr(ADDR_PENDING, 32'h10);
        check_rd(ADDR_PENDING, 32'h10, "set_wins");
        wr(ADDR_PENDING, 32'h10);
        check_rd(ADDR_PENDING, 32'h0, "w1c_clears");
        irq[4] = 1'b0;
        idle(4);

        // 6: no preemption during REQ, then the higher priority source
        wr(ADDR_MASK, 32'h1F);
        exp_cause_q.push_back(3'd3);
        irq[3] = 1'b1;
        wait_req(12);
        exp_cause_q.push_back(3'd0);
        irq[0] = 1'b1;
        idle(6);
        check_rd(ADDR_STATUS,  32'hD, "no_preempt");
        check_rd(ADDR_PENDING, 32'h9, "both_pending");
        pulse_ack();
        pulse_eret();
        wait_req(6);
        check_rd(ADDR_STATUS, 32'h1, "after_eret_cause0");
        pulse_ack();
        pulse_eret();
        check_rd(ADDR_STATUS, 32'h0, "final_idle");
        irq = '0;
        wr(ADDR_STATUS, 32'hFFFF_FFFF);
        check_rd(ADDR_STATUS, 32'h0, "status_read_only");
        wr(ADDR_MASK, 32'hFFFF_FFE1);
        check_rd(ADDR_MASK, 32'h1, "mask_upper_bits");
        idle(6);

        end_chk = 1'b1;
        @(posedge clk); #1;
        end_chk = 1'b0;
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt controller between the board-level 5-bit interrupt inputs (i_interruption) and core0 on the MotherBoard.
- Synchronises raw asynchronous interrupt lines.
- Latches edge-triggered sources and applies a mask.
- Selects one source by fixed priority and presents it to the core with a req/ack/eret handshake.
- The core configures it through a small word-addressed register port.

Parameters:
- NUM_SRC, 5, number of interrupt sources (max 8).
- SYNC_STAGES, 2, synchroniser flip-flops per source (min 2).
- CAUSE_W, 3, width of the cause index (must be at least clog2(NUM_SRC)).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i_interruption  in  NUM_SRC  raw asynchronous interrupt lines, active-high.
- i_reg_we  in  1  register write strobe.
- i_reg_addr  in  2  register select.
- i_reg_wdata  in  32  register write data.
- o_reg_rdata  out  32  register read data, combinational from i_reg_addr.
- o_int_req  out  1  interrupt request to core.
- o_int_cause  out  CAUSE_W  index of the requested source, stable while o_int_req=1.
- i_int_ack  in  1  core accepts the request (one-cycle pulse).
- i_eret  in  1  core leaves the handler (one-cycle pulse).

Behaviour:
Reset:
- All synchroniser flops, PENDING, MASK, state, o_int_req and o_int_cause reset to 0.
- MODE resets to all 1s (every source edge-triggered).
- Reset takes effect immediately and asynchronously, including mid-request or mid-service.

Synchronisation and pending:
- Each line passes through SYNC_STAGES flops. Edge detection compares the last sync stage with a delay flop.
- Edge mode (MODE[i]=1): a synchronised rising edge sets PENDING[i].
  - It is cleared by ack of that source, or by a PENDING write with bit i=1 (write-1-to-clear).
  - If a set and a clear land in the same cycle, set wins.
- Level mode (MODE[i]=0): PENDING[i] mirrors the synchronised level each cycle. Ack and W1C have no effect.
- The effective request vector is PENDING & MASK.

Priority:
- Lowest index wins.
- Ties are impossible: exactly one cause is encoded.

FSM states: IDLE, REQ, SERVICE.
- IDLE: o_int_req=0.
  - If the effective vector is nonzero, latch the priority-encoded index into o_int_cause and go to REQ.
- REQ: o_int_req=1; o_int_cause is held constant.
  - i_int_ack=1 → SERVICE. In the same edge, clear PENDING[cause] if that source is edge mode.
  - Otherwise, if the effective bit of the latched cause drops (level deassert, W1C, or mask write) → IDLE, with o_int_req low next cycle.
  - Otherwise stay in REQ. A higher-priority source arriving during REQ does not preempt it.
- SERVICE: o_int_req=0; o_int_cause keeps its last value.
  - i_eret=1 → IDLE. No nesting.
  - i_int_ack in SERVICE is ignored.
  - An i_eret in IDLE or REQ is ignored.

Latency:
- Raw line rises and is first sampled at edge 1.
- The synchronised edge is visible after edge SYNC_STAGES.
- PENDING is set at edge SYNC_STAGES+1.
- o_int_req is high after edge SYNC_STAGES+2. With default parameters, that is 4 edges from first sample.
- From i_eret with another source pending: IDLE for exactly one cycle, then REQ.

Registers (32-bit; unused upper bits read 0 and ignore writes):
- addr 0 MASK: RW, bit i enables source i.
- addr 1 MODE: RW, 1 = edge, 0 = level.
- addr 2 PENDING: read current; write = W1C on edge-mode bits only.
- addr 3 STATUS: RO. [1:0] = state (IDLE=0, REQ=1, SERVICE=2); [2+CAUSE_W-1:2] = o_int_cause. Writes ignored.

Register write timing:
- Writes take effect at the clock edge.
- The FSM sees new MASK/MODE values the following cycle.

Decomposition:
- Package int_ctrl_pkg holds:
  - state enum IDLE/REQ/SERVICE;
  - register address constants ADDR_MASK=0, ADDR_MODE=1, ADDR_PENDING=2, ADDR_STATUS=3;
  - MODE reset value.
- Sub-module int_sync: one per source. SYNC_STAGES synchroniser plus delay flop; outputs the synchronised level and a one-cycle rise pulse.
- Pending logic, priority encoder, FSM and register file stay in int_ctrl.

Test Plan:
1. Reset low mid-REQ (source 1 requesting) → o_int_req=0 immediately. After release: MASK=0, MODE=5'b11111, PENDING=0, STATUS=0.
2. MASK=5'b00001; raise i_interruption[0] at edge 1 → o_int_req=1 with cause=0 after edge 4. Ack → SERVICE, PENDING=0. Eret → IDLE with no re-request.
3. MASK=5'b11111; raise sources 3 and 1 in the same cycle → cause=1 first. Ack, then eret → IDLE for one cycle, then REQ with cause=3.
4. MODE[2]=0, MASK[2]=1; hold line 2 high → REQ cause=2. Drop line 2 before ack → REQ withdrawn, IDLE two edges after sync. Writing PENDING=5'b00100 has no effect while the line is high.
5. Edge source 4 pending and masked; write PENDING=5'b10000 in the same cycle as a new synchronised edge on line 4 → PENDING[4] stays 1 (set wins). A plain W1C later → 0.
6. In REQ with cause=3, source 0 rises → cause stays 3 until ack. After eret: REQ with cause=0.
